aes128_dec_core: RTL and testbench

Iterative AES-128 inverse cipher (FIPS-197 §5.3): accepts one 128-bit ciphertext block over a valid/ready handshake and returns the plaintext after a fixed 11-cycle latency, one round per clock. It is the decrypt-path counterpart of the encrypt round datapath. It uses the same state packing: MSB byte is state byte 0, column-major, so byte 4c+r sits at row r, column c. Round keys come from an external expanded-key store indexed by this block; the block does no key expansion.

---
 rtl/aes128_dec_core.sv | 191 +++++++++++++++++++
 tb/tb_aes128_dec_core.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_dec_core.sv
// aes128_dec_core
// Iterative AES-128 inverse cipher, one round per clock, fixed 11-cycle
// latency from accept to first out_valid_o.
//
// State packing: MSB byte is state byte 0, column-major, so byte 4c+r is
// row r, column c. Round keys come from an external expanded-key store
// addressed by rk_idx_o, which must answer combinationally on rk_i.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   in_valid_i   ciphertext on ct_i is valid
//   in_ready_o   core can accept a block (IDLE only)
//   ct_i         ciphertext block
//   rk_idx_o     round-key index requested this cycle (0..10)
//   rk_i         round key for rk_idx_o, same cycle
//   out_valid_o  plaintext on pt_o is valid
//   out_ready_i  downstream accepts pt_o
//   pt_o         plaintext block (driven from the state register)
//   busy_o       high in ROUND or DONE
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a ciphertext; initial AddRoundKey with rk[10]
// ROUND | one inverse round per cycle, rnd counts 9 down to 0
// DONE  | plaintext held on pt_o until out_ready_i
module aes128_dec_core (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] ct_i,
  output logic [3:0]   rk_idx_o,
  input  logic [127:0] rk_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] pt_o,
  output logic         busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_e;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Row r rotates right by r: out byte 4c+r takes in byte 4((c-r) mod 4)+r.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
    end
    return o;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Constants 09/0b/0d/0e are assembled from x2, x4, x8 so only xtime
  // stages and XORs are needed.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] state_q, state_d;
  logic [127:0] round_t;
  logic [127:0] round_mix;

  assign round_t   = inv_sub_bytes(inv_shift_rows(state_q)) ^ rk_i;
  assign round_mix = inv_mix_columns(round_t);
  assign pt_o      = state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q   <= IDLE;
      rnd_q   <= 4'd0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      rnd_q   <= rnd_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    rnd_d       = rnd_q;
    state_d     = state_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;
    rk_idx_o    = rnd_q;
    unique case (fsm_q)
      IDLE: begin
        in_ready_o = 1'b1;
        rk_idx_o   = 4'd10;
        if (in_valid_i) begin
          state_d = ct_i ^ rk_i;
          rnd_d   = 4'd9;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        busy_o = 1'b1;
        if (rnd_q != 4'd0) begin
          state_d = round_mix;
          rnd_d   = rnd_q - 4'd1;
        end else begin
          // Last round skips InvMixColumns.
          state_d = round_t;
          fsm_d   = DONE;
        end
      end
      DONE: begin
        busy_o      = 1'b1;
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          fsm_d = IDLE;
        end
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_aes128_dec_core.sv
module tb_aes128_dec_core;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] ct, rk, pt;
  logic [3:0]   rk_idx;
  logic [127:0] rk_mem [16];
  logic [127:0] exp_q [$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           last_acc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expanded-key store with same-cycle response.
  always_comb rk = rk_mem[rk_idx];

  aes128_dec_core dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .ct_i        (ct),
    .rk_idx_o    (rk_idx),
    .rk_i        (rk),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .pt_o        (pt),
    .busy_o      (busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp  = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Forward cipher with the loaded key store; used to build random vectors.
  function automatic logic [127:0] encrypt(input logic [127:0] p);
    logic [127:0] s, t;
    logic [7:0]   a0, a1, a2, a3;
    s = p ^ rk_mem[0];
    for (int r = 1; r <= 10; r++) begin
      t = '0;
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++)
          t[127-8*(4*c+j) -: 8] = SBOX[gb(s, 4*((c+j)%4)+j)];
      s = t;
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = gb(t, 4*c); a1 = gb(t, 4*c+1); a2 = gb(t, 4*c+2); a3 = gb(t, 4*c+3);
          s[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                               a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                               a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                               xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
      end
      s = s ^ rk_mem[r];
    end
    return s;
  endfunction

  // Drives a block, waits for its accept edge; returns at #1 after it.
  task automatic send(input logic [127:0] c, input logic [127:0] e, input bit push);
    int n;
    n = 0;
    ct = c;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_wait", 128'(in_ready), 128'(1'b1));
    chk("rk_idx_accept", 128'(rk_idx), 128'(4'd10));
    @(posedge clk); #1;
    last_acc = cyc;
    in_valid = 1'b0;
    if (push) exp_q.push_back(e);
  endtask

  // Runs from cycle 1 of ROUND until out_valid; checks key index, latency, data.
  task automatic recv(input bit noise);
    int k;
    logic [127:0] e;
    k = 1;
    while (!out_valid && k < 30) begin
      if (k <= 10) chk("rk_idx_round", 128'(rk_idx), 128'(10 - k));
      chk("busy_round", 128'(busy), 128'(1'b1));
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        ct = {$urandom, $urandom, $urandom, $urandom};
      end
      @(posedge clk); #1;
      k++;
    end
    in_valid = 1'b0;
    chk("out_valid_seen", 128'(out_valid), 128'(1'b1));
    chk("latency_cycle", 128'(k), 128'(11));
    chk("sb_nonempty", 128'(exp_q.size() != 0), 128'(1'b1));
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    chk("pt_value", pt, e);
  endtask

  initial begin
    logic [127:0] key, p;
    int prev_acc;
    bit saw_ov;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    ct = '0;
    for (int i = 0; i < 16; i++) rk_mem[i] = '0;
    load_key(KEY_C1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
    chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_busy", 128'(busy), 128'(1'b0));
    chk("rst_rk_idx", 128'(rk_idx), 128'(4'd10));
    chk("rst_pt", pt, 128'h0);
    rst = 1'b0;

    // FIPS-197 C.1
    send(CT_C1, PT_C1, 1'b1);
    recv(1'b0);

    // FIPS-197 Appendix B
    load_key(KEY_B);
    send(CT_B, PT_B, 1'b1);
    recv(1'b0);

    // Backpressure with a second block waiting on in_valid
    load_key(KEY_C1);
    send(CT_C1, PT_C1, 1'b1);
    out_ready = 1'b0;
    recv(1'b0);
    load_key(KEY_B);
    ct = CT_B;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("bp_pt_stable", pt, PT_C1);
      chk("bp_out_valid", 128'(out_valid), 128'(1'b1));
      chk("bp_in_ready", 128'(in_ready), 128'(1'b0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_in_ready", 128'(in_ready), 128'(1'b1));
    chk("bp_idle_busy", 128'(busy), 128'(1'b0));
    @(posedge clk); #1;
    chk("bp_second_accept", 128'(busy), 128'(1'b1));
    in_valid = 1'b0;
    exp_q.push_back(PT_B);
    recv(1'b0);

    // Reset in ROUND cycle 5
    load_key(KEY_C1);
    send(CT_C1, PT_C1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_in_ready", 128'(in_ready), 128'(1'b1));
    chk("mid_rst_busy", 128'(busy), 128'(1'b0));
    chk("mid_rst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("mid_rst_pt", pt, 128'h0);
    saw_ov = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) saw_ov = 1'b1;
    end
    chk("mid_rst_no_out", 128'(saw_ov), 128'(1'b0));
    send(CT_C1, PT_C1, 1'b1);
    recv(1'b0);

    // Noise on in_valid/ct while rounds run
    load_key(KEY_B);
    send(CT_B, PT_B, 1'b1);
    recv(1'b1);

    // Back-to-back random blocks
    prev_acc = 0;
    for (int i = 0; i < 100; i++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      p   = {$urandom, $urandom, $urandom, $urandom};
      load_key(key);
      send(encrypt(p), p, 1'b1);
      if (i > 0) chk("b2b_period", 128'(last_acc - prev_acc), 128'(12));
      prev_acc = last_acc;
      recv(1'b0);
    end
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
